// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared types and default parameters for the operand loader.
//   load_state_e        - FSM state (LOAD_A, LOAD_B, SHOW)
//   OPERAND_W_DEF       - default operand width
//   DEBOUNCE_CYCLES_DEF - default debounce length (1 ms at 50 MHz)
package operand_loader_pkg;
  localparam int OPERAND_W_DEF       = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, SHOW} load_state_e;
endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button inputs and operand outputs of the operand loader.
//   sw, key_n          - raw switch value and raw active-low button (driven by master)
//   a, b               - held operands
//   sel_b              - 1 when the next press loads B
//   operands_valid     - complete, freshly loaded pair
//   load_pulse         - one-cycle strobe after an a/b update
// Modports: master (board/bench side), slave (operand_loader).
import operand_loader_pkg::*;

interface operand_loader_if #(parameter int OPERAND_W = OPERAND_W_DEF);
  logic [OPERAND_W-1:0] sw;
  logic                 key_n;
  logic [OPERAND_W-1:0] a;
  logic [OPERAND_W-1:0] b;
  logic                 sel_b;
  logic                 operands_valid;
  logic                 load_pulse;

  modport master (output sw, key_n, input a, b, sel_b, operands_valid, load_pulse);
  modport slave  (input sw, key_n, output a, b, sel_b, operands_valid, load_pulse);
endinterface

// File: rtl/operand_loader_key_debouncer.sv
// key_debouncer: 2-flop synchroniser, stability counter and press detect for
// a raw active-low push button.
//   clk, rst_n - clock, asynchronous active-low reset
//   key_n      - raw button, asynchronous to clk
//   press      - one-cycle strobe on a debounced 1->0 transition
//   level      - debounced button level (1 = released)
import operand_loader_pkg::*;

module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press,
  output logic level
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic             key_s;
  logic [CNT_W-1:0] cnt;

  assign key_s = sync[1];

  // Synchroniser and level reset to "released" so a key held through reset
  // release still registers as one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (key_s == level) begin
        cnt <= '0;                        // any bounce restarts the count
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= key_s;
        cnt   <= '0;
        press <= ~key_s;                  // only the falling edge is a press
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: captures operand A then B from the slide switches on
// successive debounced button presses and holds them for the multiplier.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - operand_loader_if.slave (sw, key_n in; a, b, sel_b,
//                operands_valid, load_pulse out)
// Build option: SW_ACTIVE_LOW_EN captures ~sw so a/b come out true-polarity
// on boards whose switches read 0 when up.
import operand_loader_pkg::*;

module operand_loader #(
  parameter int OPERAND_W       = OPERAND_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                clk,
  input logic                rst_n,
  operand_loader_if.slave    bus
);
  load_state_e          state, state_nxt;
  logic                 press, key_level;
  logic                 load_a, load_b;
  logic [OPERAND_W-1:0] cap;
  logic [OPERAND_W-1:0] a_q, b_q;
  logic                 valid_q, pulse_q;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_n),
    .press (press),
    .level (key_level)
  );

`ifdef SW_ACTIVE_LOW_EN
  assign cap = ~bus.sw;
`else
  assign cap = bus.sw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nxt;
  end

  // The strobe is only ever high while the debounced key is down; gating on
  // the level keeps a load tied to a held key.
  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    if (press && !key_level) begin
      case (state)
        LOAD_A:  begin load_a = 1'b1; state_nxt = LOAD_B; end
        LOAD_B:  begin load_b = 1'b1; state_nxt = SHOW;   end
        SHOW:    begin load_a = 1'b1; state_nxt = LOAD_B; end
        default: state_nxt = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= load_a | load_b;
      if (load_a) begin
        a_q     <= cap;
        valid_q <= 1'b0;                  // a new A invalidates the old pair
      end
      if (load_b) begin
        b_q     <= cap;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.operands_valid = valid_q;
  assign bus.load_pulse     = pulse_q;
  assign bus.sel_b          = (state == LOAD_B);
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized and directed stimulus for operand_loader
// (DEBOUNCE_CYCLES = 4) against a behavioural reference model.
import operand_loader_pkg::*;

module tb_operand_loader;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_loader_if #(.OPERAND_W(8)) bus();

  operand_loader #(.OPERAND_W(8), .DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int lp_seen = 0;

  // Reference model: key_n seen two edges late; the debounced level flips
  // once the last DC delayed samples all disagree with it. Loads alternate
  // A, B, A, B ... so the load count alone gives sel_b and validity.
  logic       k1, k2;
  logic       win[$];
  logic       m_lvl, m_press, m_lp;
  int         m_loads;
  logic [7:0] m_a, m_b;

  function automatic logic [7:0] cap(input logic [7:0] s);
`ifdef SW_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k1 = 1'b1; k2 = 1'b1;
    win.delete();
    m_lvl = 1'b1; m_press = 1'b0; m_lp = 1'b0;
    m_loads = 0; m_a = '0; m_b = '0;
  endtask

  task automatic model_edge(input logic kn, input logic [7:0] s);
    logic ks;
    bit   all_diff;
    m_lp = m_press;
    if (m_press) begin
      if (m_loads % 2 == 0) m_a = cap(s);
      else                  m_b = cap(s);
      m_loads++;
    end
    m_press = 1'b0;
    ks = k2; k2 = k1; k1 = kn;
    win.push_back(ks);
    if (win.size() > DC) void'(win.pop_front());
    if (win.size() == DC) begin
      all_diff = 1'b1;
      foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        m_press = m_lvl;
        m_lvl   = ~m_lvl;
        win.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("a",          32'(bus.a),              32'(m_a));
    chk("b",          32'(bus.b),              32'(m_b));
    chk("sel_b",      32'(bus.sel_b),          32'(m_loads % 2 == 1));
    chk("valid",      32'(bus.operands_valid), 32'(m_loads > 0 && m_loads % 2 == 0));
    chk("load_pulse", 32'(bus.load_pulse),     32'(m_lp));
    chk("level",      32'(dut.u_deb.level),    32'(m_lvl));
    if (bus.load_pulse) lp_seen++;
  endtask

  // Called at a negedge: drive, let one posedge happen, check at next negedge.
  task automatic step(input logic kn, input logic [7:0] s);
    bus.key_n = kn;
    bus.sw    = s;
    @(posedge clk);
    if (rst_n) model_edge(kn, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press_release(input logic [7:0] s, input int hold, input int rel);
    repeat (hold) step(1'b0, s);
    repeat (rel)  step(1'b1, s);
  endtask

  initial begin
    int lat, mx, p0;
    bit found;
    bus.key_n = 1'b1;
    bus.sw    = '0;
    @(negedge clk);
    do_reset();

    // idle after reset
    p0 = lp_seen;
    repeat (20) step(1'b1, 8'h00);
    chk("idle_pulses", 32'(lp_seen - p0), 0);

    // load A, measure latency from key fall
    p0 = lp_seen; found = 1'b0; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 8'h0C);
      if (!found && bus.a == cap(8'h0C)) begin found = 1'b1; lat = i; end
    end
    chk("latency_a", 32'(lat), 7);
    chk("sel_b_after_a", 32'(bus.sel_b), 1);
    repeat (10) step(1'b1, 8'h0C);
    chk("one_pulse_a", 32'(lp_seen - p0), 1);

    // load B
    press_release(8'h15, 10, 10);
    chk("b_loaded", 32'(bus.b), 32'(cap(8'h15)));
    chk("valid_pair", 32'(bus.operands_valid), 1);

    // bounce: never stable for DC cycles
    p0 = lp_seen; mx = 0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) begin
        step(j < 2 ? 1'b0 : 1'b1, 8'h77);
        if (int'(dut.u_deb.cnt) > mx) mx = int'(dut.u_deb.cnt);
      end
    end
    repeat (10) begin
      step(1'b1, 8'h77);
      if (int'(dut.u_deb.cnt) > mx) mx = int'(dut.u_deb.cnt);
    end
    chk("bounce_pulses", 32'(lp_seen - p0), 0);
    chk("bounce_cnt_lt3", 32'(mx < 3), 1);
    chk("bounce_valid", 32'(bus.operands_valid), 1);

    // press in SHOW reloads A, keeps B
    press_release(8'hFF, 10, 10);
    chk("show_a", 32'(bus.a), 32'(cap(8'hFF)));
    chk("show_b_kept", 32'(bus.b), 32'(cap(8'h15)));
    chk("show_valid", 32'(bus.operands_valid), 0);
    chk("show_sel_b", 32'(bus.sel_b), 1);

    // long hold: exactly one load
    p0 = lp_seen;
    press_release(8'h3C, 100, 20);
    chk("hold_pulses", 32'(lp_seen - p0), 1);

    // back to LOAD_B, then reset mid-debounce
    press_release(8'h42, 10, 10);
    chk("pre_rst_sel_b", 32'(bus.sel_b), 1);
    repeat (4) step(1'b0, 8'h99);
    chk("mid_cnt", 32'(dut.u_deb.cnt), 2);
    bus.key_n = 1'b1;
    do_reset();
    chk("rst_a", 32'(bus.a), 0);
    p0 = lp_seen;
    repeat (20) step(1'b1, 8'h99);
    chk("no_stale_press", 32'(lp_seen - p0), 0);

    // key held low through reset release
    bus.key_n = 1'b0;
    do_reset();
    p0 = lp_seen;
    press_release(8'hA5, 15, 10);
    chk("held_rst_pulses", 32'(lp_seen - p0), 1);
    chk("held_rst_a", 32'(bus.a), 32'(cap(8'hA5)));

    // randomized segments
    for (int seg = 0; seg < 300; seg++) begin
      logic       kn;
      logic [7:0] s;
      int         len;
      if ($urandom_range(0, 59) == 0) do_reset();
      kn  = 1'(seg % 2 == 0);
      len = $urandom_range(1, 9);
      s   = 8'($urandom);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) s = 8'($urandom);
        step(kn, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the 8-bit multiplier/display path.
- Captures operand A, then operand B, from the 8 slide switches on successive presses of one push button.
- Holds both operands stable for the combinational multiplier and 4-digit display.
- Synchronises and debounces the raw button, and flags when a complete operand pair is loaded.

Parameters:
- OPERAND_W, 8: operand width in bits.
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised cycles needed before the debounced key level changes. Minimum 1. The default gives 1 ms at 50 MHz.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- sw, input, OPERAND_W: raw switch value, quasi-static.
- key_n, input, 1: raw active-low push button, asynchronous to clk.
- a, output, OPERAND_W: registered operand A.
- b, output, OPERAND_W: registered operand B.
- sel_b, output, 1: 0 = next press loads A; 1 = next press loads B. Drives an "A/B" indicator LED.
- operands_valid, output, 1: high while a and b form a complete, freshly loaded pair.
- load_pulse, output, 1: one-cycle strobe in the cycle after a or b updates.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low: rst_n low forces all state immediately, and release is sampled on clk.
- Reset values:
  - a = 0, b = 0, operands_valid = 0, load_pulse = 0, sel_b = 0.
  - FSM = LOAD_A.
  - Synchroniser flops = 1, debounced level = 1 (released), debounce counter = 0.
- Synchroniser: key_n passes through a 2-flop synchroniser. Only its output (key_s) is used.
- Debounce:
  - The counter increments each cycle while key_s differs from the debounced level.
  - The counter clears to 0 in any cycle where key_s equals the debounced level, so a bounce restarts the count.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes key_s on the next edge and the counter clears.
- Press detection:
  - A press is a 1→0 transition of the debounced level. It produces a 1-cycle internal press strobe.
  - A release (0→1) produces nothing.
- FSM states: LOAD_A, LOAD_B, SHOW. Transitions on press:
  - LOAD_A: a <= sw; operands_valid <= 0; go to LOAD_B.
  - LOAD_B: b <= sw; operands_valid <= 1; go to SHOW.
  - SHOW: a <= sw; operands_valid <= 0; go to LOAD_B. b keeps its old value until reloaded.
  - With no press, every state holds and all registers keep their value.
- sel_b = 1 in LOAD_B, 0 otherwise. It is decoded from registered state, so it has no glitches.
- load_pulse rises the cycle after any a/b write and stays high exactly 1 cycle.
- Latency: key_n held low from edge N gives:
  - debounced level = 0 at edge N+2+DEBOUNCE_CYCLES;
  - press strobe in the following cycle;
  - a/b updated at edge N+3+DEBOUNCE_CYCLES.
- sw is sampled only on the press cycle. Switch changes at any other time have no effect.
- Boundary conditions:
  - Key held low through reset release: counts as one press after DEBOUNCE_CYCLES, because the debounced level resets to released.
  - Holding the key: exactly one load per press. Auto-repeat is not supported.
  - Reset mid-debounce or mid-sequence: everything returns to reset values, and partially loaded operands are discarded.

Optional Feature:
- Macro: SW_ACTIVE_LOW_EN.
- Defined: captured value = ~sw. Use this for boards whose switches read 0 when up, so that a and b are true-polarity and downstream stages need no inversion.
- Undefined: captured value = sw unchanged.
- Reset values and timing are identical in both builds.

Decomposition:
- Package operand_loader_pkg:
  - state enum load_state_e {LOAD_A, LOAD_B, SHOW};
  - localparam OPERAND_W_DEF = 8;
  - localparam DEBOUNCE_CYCLES_DEF = 50000.
- Sub-module key_debouncer (parameter DEBOUNCE_CYCLES):
  - inputs clk, rst_n, key_n;
  - outputs press (1-cycle strobe) and level;
  - contains the synchroniser, counter and edge detect.
- operand_loader contains the FSM and the operand registers.

Test Plan (all with DEBOUNCE_CYCLES = 4):
- Reset then idle 20 cycles → a = 0, b = 0, operands_valid = 0, sel_b = 0, load_pulse never asserted.
- sw = 8'h0C, press held 10 cycles → a = 8'h0C exactly 7 cycles after key_n falls; sel_b = 1; one load_pulse. Then sw = 8'h15 and press → b = 8'h15, operands_valid = 1.
- Bounce: key_n toggles low/high every 2 cycles for 12 cycles, then stays high → no load, counter never reaches 3, state unchanged.
- In SHOW, sw = 8'hFF, press → a = 8'hFF, b keeps 8'h15, operands_valid = 0, state LOAD_B.
- Key held 100 cycles, then released → exactly one load_pulse; the release causes no further load.
- rst_n pulsed low mid-debounce, with the counter at 2 in LOAD_B → all outputs reset immediately, no stale press afterwards. With SW_ACTIVE_LOW_EN and sw = 8'hF0, press → a = 8'h0F.
